// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: receive-side frame sequencer for the UART RX path.
// Owns the oversampling edge counter and the bit counter, steps each frame
// through start, data, optional parity and stop, strobes the sampler,
// deserializer and checker enables, and reports data_valid plus the
// registered error flags one cycle after the stop bit has been checked.
module uart_rx_fsm #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic                      dat_samp_en,
  output logic                      deser_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      data_valid,
  output logic                      Parity_Error,
  output logic                      Stop_Error
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE        = PRESCALE_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0]  BIT_ONE       = BIT_CNT_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0]  LAST_DATA_BIT = BIT_CNT_WIDTH'(DATA_WIDTH);

  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q, par_en_d;
  logic                      par_flag_q, par_flag_d;
  logic                      stp_flag_q, stp_flag_d;
  logic                      done_q, done_d;
  logic                      data_valid_q, data_valid_d;
  logic                      parity_error_q, parity_error_d;
  logic                      stop_error_q, stop_error_d;

  logic last_edge;
  logic samp_en_c, deser_en_c, strt_chk_en_c, par_chk_en_c, stp_chk_en_c;

  // The final oversample of a bit, measured against the ratio latched at frame start.
  assign last_edge = (state_q != IDLE) && (edge_cnt_q == (prescale_q - PS_ONE));

  // Next-state, counter and enable logic; the frame result is published one cycle after stop.
  always_comb begin
    state_d        = state_q;
    edge_cnt_d     = '0;
    bit_cnt_d      = '0;
    prescale_d     = prescale_q;
    par_en_d       = par_en_q;
    par_flag_d     = par_flag_q;
    stp_flag_d     = stp_flag_q;
    done_d         = 1'b0;
    data_valid_d   = 1'b0;
    parity_error_d = parity_error_q;
    stop_error_d   = stop_error_q;
    samp_en_c      = (state_q != IDLE);
    deser_en_c     = 1'b0;
    strt_chk_en_c  = 1'b0;
    par_chk_en_c   = 1'b0;
    stp_chk_en_c   = 1'b0;

    if (done_q) begin
      data_valid_d   = ~(par_flag_q | stp_flag_q);
      parity_error_d = par_flag_q;
      stop_error_d   = stp_flag_q;
    end

    if (state_q != IDLE) begin
      edge_cnt_d = last_edge ? '0 : (edge_cnt_q + PS_ONE);
      bit_cnt_d  = last_edge ? (bit_cnt_q + BIT_ONE) : bit_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d    = START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_flag_d = 1'b0;
        end
      end
      START: begin
        if (last_edge) begin
          strt_chk_en_c = 1'b1;
          if (strt_glitch) begin
            state_d    = IDLE;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (last_edge) begin
          deser_en_c = 1'b1;
          if (bit_cnt_q == LAST_DATA_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (last_edge) begin
          par_chk_en_c = 1'b1;
          par_flag_d   = par_err;
          state_d      = STOP;
        end
      end
      STOP: begin
        if (last_edge) begin
          stp_chk_en_c = 1'b1;
          stp_flag_d   = stp_err;
          done_d       = 1'b1;
          state_d      = IDLE;
          edge_cnt_d   = '0;
          bit_cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset that also aborts a frame.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= IDLE;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      prescale_q     <= '0;
      par_en_q       <= 1'b0;
      par_flag_q     <= 1'b0;
      stp_flag_q     <= 1'b0;
      done_q         <= 1'b0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      prescale_q     <= prescale_d;
      par_en_q       <= par_en_d;
      par_flag_q     <= par_flag_d;
      stp_flag_q     <= stp_flag_d;
      done_q         <= done_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  // Enables are forced low while reset is held so no strobe escapes before the state register clears.
  always_comb begin
    dat_samp_en = samp_en_c & RST;
    deser_en    = deser_en_c & RST;
    strt_chk_en = strt_chk_en_c & RST;
    par_chk_en  = par_chk_en_c & RST;
    stp_chk_en  = stp_chk_en_c & RST;
  end

  assign edge_cnt     = edge_cnt_q;
  assign bit_cnt      = bit_cnt_q;
  assign data_valid   = data_valid_q;
  assign Parity_Error = parity_error_q;
  assign Stop_Error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed plus randomized frames against a timing model
// that predicts, from frame parameters alone, the absolute cycle of every
// strobe and the frame result.
module tb_uart_rx_fsm;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       Parity_Error;
  logic       Stop_Error;

  uart_rx_fsm #(
    .DATA_WIDTH(8),
    .PRESCALE_WIDTH(6),
    .BIT_CNT_WIDTH(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .PAR_EN(PAR_EN),
    .Prescale(Prescale),
    .strt_glitch(strt_glitch),
    .par_err(par_err),
    .stp_err(stp_err),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en),
    .deser_en(deser_en),
    .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en),
    .data_valid(data_valid),
    .Parity_Error(Parity_Error),
    .Stop_Error(Stop_Error)
  );

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   expDeser[$], actDeser[$];
  int   expStrt[$], actStrt[$];
  int   expPar[$], actPar[$];
  int   expStp[$], actStp[$];
  int   expDv[$], actDv[$];
  int   expSamp = 0;
  int   actSamp = 0;
  logic expPerr = 1'b0;
  logic expSerr = 1'b0;

  // Free-running clock, 10 time units per cycle.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Cycle index: cycle n is the interval after the nth rising edge.
  always @(posedge CLK) cyc <= cyc + 1;

  // Record the cycle of every strobe, sampled just before the next rising edge.
  always @(negedge CLK) begin
    #4;
    if (deser_en === 1'b1)    actDeser.push_back(cyc);
    if (strt_chk_en === 1'b1) actStrt.push_back(cyc);
    if (par_chk_en === 1'b1)  actPar.push_back(cyc);
    if (stp_chk_en === 1'b1)  actStp.push_back(cyc);
    if (data_valid === 1'b1)  actDv.push_back(cyc);
    if (dat_samp_en === 1'b1) actSamp++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic compareQueue(input string tag, input int act[$], input int exp[$]);
    checkOutput({tag, "_count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checkOutput({tag, "_cycle"}, (i < act.size()) ? act[i] : -1, exp[i]);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_edge_cnt"}, edge_cnt, 0);
    checkOutput({tag, "_bit_cnt"}, bit_cnt, 0);
    checkOutput({tag, "_strobes"},
                {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en}, 0);
    checkOutput({tag, "_data_valid"}, data_valid, 0);
    checkOutput({tag, "_Parity_Error"}, Parity_Error, 0);
    checkOutput({tag, "_Stop_Error"}, Stop_Error, 0);
  endtask

  task automatic randomizeCheckers();
    strt_glitch = 1'($urandom_range(0, 1));
    par_err     = 1'($urandom_range(0, 1));
    stp_err     = 1'($urandom_range(0, 1));
  endtask

  // Idle the line, let the frame result land, then compare the model against everything recorded.
  task automatic settleAndCheck(input string tag);
    @(negedge CLK);
    RX_IN = 1'b1;
    randomizeCheckers();
    repeat (4) begin
      @(negedge CLK);
      randomizeCheckers();
    end
    compareQueue({tag, "_deser"}, actDeser, expDeser);
    compareQueue({tag, "_strt_chk"}, actStrt, expStrt);
    compareQueue({tag, "_par_chk"}, actPar, expPar);
    compareQueue({tag, "_stp_chk"}, actStp, expStp);
    compareQueue({tag, "_data_valid"}, actDv, expDv);
    checkOutput({tag, "_samp_cycles"}, actSamp, expSamp);
    checkOutput({tag, "_Parity_Error"}, Parity_Error, expPerr);
    checkOutput({tag, "_Stop_Error"}, Stop_Error, expSerr);
    checkOutput({tag, "_idle_bit_cnt"}, bit_cnt, 0);
    checkOutput({tag, "_idle_edge_cnt"}, edge_cnt, 0);
    expDeser.delete(); actDeser.delete();
    expStrt.delete();  actStrt.delete();
    expPar.delete();   actPar.delete();
    expStp.delete();   actStp.delete();
    expDv.delete();    actDv.delete();
    expSamp = 0;
    actSamp = 0;
  endtask

  // Drive one frame starting at the next falling edge; the model predicts every strobe cycle.
  task automatic applyStimulus(input int p, input bit pe, input bit g, input bit perr,
                               input bit serr, input logic [7:0] data, input bit midChange,
                               input int abortAt);
    int          t0;
    int          nBits;
    int          len;
    int          ac;
    bit          aborted;
    logic [10:0] frameBits;
    aborted   = 1'b0;
    nBits     = 2 + 8 + (pe ? 1 : 0);
    len       = g ? p : nBits * p;
    frameBits = pe ? {1'b1, ^data, data, 1'b0} : {1'b0, 1'b1, data, 1'b0};

    @(negedge CLK);
    Prescale = 6'(p);
    PAR_EN   = pe;
    RX_IN    = 1'b0;
    randomizeCheckers();
    t0 = cyc + 1;

    expStrt.push_back(t0 + p - 1);
    if (!g) begin
      for (int k = 1; k <= 8; k++) expDeser.push_back(t0 + k * p + p - 1);
      if (pe) expPar.push_back(t0 + 10 * p - 1);
      expStp.push_back(t0 + nBits * p - 1);
      if (!(pe && perr) && !serr) expDv.push_back(t0 + nBits * p + 1);
    end
    expSamp += len;

    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      if (i == abortAt) begin
        checkOutput("bit_cnt_before_abort", bit_cnt, i / p);
        RST = 1'b0;
        ac  = t0 + i;
        while (expDeser.size() > 0 && expDeser[$] >= ac) void'(expDeser.pop_back());
        while (expStrt.size() > 0 && expStrt[$] >= ac) void'(expStrt.pop_back());
        while (expPar.size() > 0 && expPar[$] >= ac) void'(expPar.pop_back());
        while (expStp.size() > 0 && expStp[$] >= ac) void'(expStp.pop_back());
        while (expDv.size() > 0 && expDv[$] >= ac) void'(expDv.pop_back());
        expSamp -= (len - i);
        aborted = 1'b1;
        break;
      end
      if (g) RX_IN = (i < 2) ? 1'b0 : 1'b1;
      else   RX_IN = frameBits[i / p];
      randomizeCheckers();
      if (i == p - 1) strt_glitch = g;
      if (pe && !g && i == 10 * p - 1) par_err = perr;
      if (!g && i == nBits * p - 1) stp_err = serr;
      if (midChange && i == 3 * p) begin
        Prescale = 6'd32;
        PAR_EN   = ~pe;
      end
    end

    if (aborted) begin
      @(negedge CLK);
      checkQuiet("abort_in_reset");
      RST   = 1'b1;
      RX_IN = 1'b1;
      @(negedge CLK);
      checkQuiet("abort_released");
      expPerr = 1'b0;
      expSerr = 1'b0;
    end else if (!g) begin
      expPerr = pe && perr;
      expSerr = serr;
    end
  endtask

  initial begin
    int  p;
    bit  pe;
    bit  g;
    bit  perr;
    bit  serr;
    bit  chain;

    RST         = 1'b0;
    RX_IN       = 1'b1;
    PAR_EN      = 1'b0;
    Prescale    = 6'd8;
    strt_glitch = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b0;

    repeat (3) @(negedge CLK);
    checkQuiet("reset_held");
    RST = 1'b1;
    @(negedge CLK);
    checkQuiet("reset_released");
    actSamp = 0;

    $display("[TB] Prescale 8 with parity, 0xA5, clean");
    applyStimulus(8, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, -1);
    settleAndCheck("t1");

    $display("[TB] Prescale 16 without parity, back-to-back");
    applyStimulus(16, 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0, -1);
    applyStimulus(16, 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0, -1);
    settleAndCheck("t2");

    $display("[TB] start glitch discard");
    applyStimulus(8, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, -1);
    settleAndCheck("t3");

    $display("[TB] parity error then clean frame");
    applyStimulus(8, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, -1);
    settleAndCheck("t4a");
    applyStimulus(8, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, -1);
    settleAndCheck("t4b");

    $display("[TB] stop error");
    applyStimulus(16, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, -1);
    settleAndCheck("t5");

    $display("[TB] reset in DATA at bit 4, then mid-frame Prescale change");
    applyStimulus(8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 4 * 8 + 2);
    settleAndCheck("t6a");
    applyStimulus(8, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7E, 1'b1, -1);
    settleAndCheck("t6b");

    $display("[TB] randomized frames");
    for (int n = 0; n < 10; n++) begin
      p     = 8 << $urandom_range(0, 2);
      pe    = 1'($urandom_range(0, 1));
      g     = ($urandom_range(0, 4) == 0);
      perr  = 1'($urandom_range(0, 1));
      serr  = ($urandom_range(0, 3) == 0);
      chain = 1'($urandom_range(0, 1));
      applyStimulus(p, pe, g, perr, serr, 8'($urandom), 1'($urandom_range(0, 1)), -1);
      if (!chain) settleAndCheck("rand");
    end
    settleAndCheck("rand_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Receive-side sequencer for the UART RX path. It owns the oversampling edge counter and the bit counter.
- It walks each frame through start, data, optional parity and stop.
- It pulses the enables of the data sampler, deserializer and the three combinational checkers (start, parity, stop).
- It issues data_valid and the error flags at frame end. It sits between the RX pin synchronizer and the deserializer/checker datapath.

Parameters:
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_WIDTH, 6, width of Prescale and edge_cnt
- BIT_CNT_WIDTH, 4, width of bit_cnt; must hold DATA_WIDTH+2

Ports:
- CLK  input  1  system clock
- RST  input  1  reset, synchronous, active-low
- RX_IN  input  1  synchronized serial line, idle high
- PAR_EN  input  1  parity bit present in frame
- Prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32
- strt_glitch  input  1  start-checker result, valid combinationally while strt_chk_en=1
- par_err  input  1  parity-checker result, valid combinationally while par_chk_en=1
- stp_err  input  1  stop-checker result, valid combinationally while stp_chk_en=1
- edge_cnt  output  PRESCALE_WIDTH  oversample index within current bit
- bit_cnt  output  BIT_CNT_WIDTH  bit index in frame (0=start)
- dat_samp_en  output  1  sampler enable
- deser_en  output  1  one-cycle shift strobe to deserializer
- strt_chk_en  output  1  start-check enable
- par_chk_en  output  1  parity-check enable
- stp_chk_en  output  1  stop-check enable
- data_valid  output  1  one-cycle pulse, clean frame received
- Parity_Error  output  1  registered parity result of last completed frame
- Stop_Error  output  1  registered stop result of last completed frame

Behaviour:
- All flops update on posedge CLK. RST=0 at an edge forces:
  - state IDLE
  - edge_cnt=0, bit_cnt=0
  - data_valid, Parity_Error, Stop_Error = 0
  - latched Prescale/PAR_EN and internal par flag cleared
- Reset asserted mid-frame aborts the frame with no data_valid.
- States: IDLE, START, DATA, PARITY, STOP.
- last_edge = (edge_cnt == Prescale_q-1), where Prescale_q and PAR_EN_q are latched on the IDLE->START transition and held for the whole frame. Input changes mid-frame are ignored.
- Counters:
  - In IDLE, edge_cnt=0 and bit_cnt=0.
  - Otherwise edge_cnt increments each cycle and wraps to 0 on last_edge.
  - bit_cnt increments on last_edge.
- Transitions:
  - IDLE: RX_IN=0 -> START, with edge_cnt=0 on the first START cycle.
  - START on last_edge: strt_glitch=1 -> IDLE (silent discard, counters cleared); else DATA.
  - DATA on last_edge with bit_cnt==DATA_WIDTH: -> PARITY if PAR_EN_q, else STOP.
  - PARITY on last_edge: capture par_err into internal flag; -> STOP.
  - STOP on last_edge: -> IDLE. Next cycle: Parity_Error <= flag (0 if no parity); Stop_Error <= stp_err; data_valid <= ~(flag | stp_err).
- data_valid is high exactly one cycle. Parity_Error and Stop_Error hold until the next completed frame.
- Combinational enables:
  - dat_samp_en = (state != IDLE)
  - deser_en = DATA & last_edge
  - strt_chk_en = START & last_edge
  - par_chk_en = PARITY & last_edge
  - stp_chk_en = STOP & last_edge
  - All 0 in IDLE and in reset.
- Back-to-back frames:
  - After STOP the FSM spends one cycle in IDLE before it can re-enter START.
  - A start bit already low on that IDLE cycle is accepted there.
- Frame length:
  - Start to data_valid = (2+DATA_WIDTH+PAR_EN_q) * Prescale_q + 1 cycles, counted from the first START cycle.
  - Example: Prescale 8 with parity = 89.
- Illegal Prescale (not 8/16/32) is outside the specification; no checking is required.

Test Plan:
1. Prescale=8, PAR_EN=1, frame 0xA5 LSB-first with even-parity bit 0 and stop 1, checkers return 0 -> 8 deser_en pulses spaced 8 cycles; one par_chk_en, one stp_chk_en; data_valid pulse 89 cycles after first START cycle; both errors 0.
2. Prescale=16, PAR_EN=0, two back-to-back frames with one idle cycle between -> two data_valid pulses 161 cycles apart from their START cycles; par_chk_en never asserted.
3. RX_IN low for 3 cycles, strt_glitch=1 at start check -> returns to IDLE, bit_cnt=0, no deser_en, no data_valid.
4. Prescale=8, PAR_EN=1, par_err=1 at parity check -> Parity_Error=1, data_valid stays 0. Next clean frame -> Parity_Error returns to 0 with data_valid=1.
5. stp_err=1 at stop check -> Stop_Error=1, no data_valid.
6. RST=0 asserted while in DATA with bit_cnt=4 -> next cycle state IDLE, all outputs 0. Change Prescale from 8 to 32 mid-frame on a later frame -> frame timing stays at 8.
